gemm_operand_loader: RTL and testbench
======================================

GEMM_OPERAND_LOADER -- requirements
Module: gemm_operand_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 16, operand element width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, 16, read-address width in bits.
REQ-003 SHALL have parameter MATRIX_SIZE, 4, square matrix dimension N; ELEMS = N*N.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port s_valid  input  1  upstream element valid.
REQ-007 SHALL have port s_ready  output  1  loader accepts element.
REQ-008 SHALL have port s_data  input  DATA_WIDTH  element, row-major, A then B.
REQ-009 SHALL have port s_last  input  1  marks final B element; used only per REQ-030.
REQ-010 SHALL have port gemm_start  output  1  one-cycle start pulse to the GEMM stage.
REQ-011 SHALL have port gemm_done  input  1  GEMM stage completion.
REQ-012 SHALL have port a_rd_addr  input  ADDR_WIDTH  A read address, row-major i*N+k.
REQ-013 SHALL have port a_rd_data  output  DATA_WIDTH  A read data.
REQ-014 SHALL have port b_rd_addr  input  ADDR_WIDTH  B read address, row-major k*N+j.
REQ-015 SHALL have port b_rd_data  output  DATA_WIDTH  B read data.
REQ-016 SHALL have port busy  output  1  high in START and RUN.
REQ-017 SHALL have port load_err  output  1  sticky framing error.

Function
REQ-018 SHALL implement states LOAD_A, LOAD_B, START, RUN; reset state LOAD_A.
REQ-019 SHALL drive s_ready=1 exactly in LOAD_A and LOAD_B, else 0 (Moore, no s_valid dependency).
REQ-020 SHALL, on each s_valid&&s_ready cycle, write s_data to the current matrix at index cnt and increment cnt.
REQ-021 SHALL, on the handshake with cnt==ELEMS-1, clear cnt and advance LOAD_A->LOAD_B or LOAD_B->START.
REQ-022 SHALL hold cnt and stored data unchanged on cycles without handshake (upstream stalls).
REQ-023 SHALL assert gemm_start for exactly one cycle in START, then enter RUN.
REQ-024 SHALL remain in RUN until gemm_done==1, then return to LOAD_A next cycle; gemm_done outside RUN ignored.
REQ-025 SHALL return read data one cycle after address (registered reads), in every state.
REQ-026 SHALL return 0 for read addresses >= ELEMS.
REQ-027 SHALL return pre-write data when a read and write hit the same address in the same cycle.
REQ-028 SHALL keep matrix contents across operations; a new load overwrites in place.

Reset
REQ-029 SHALL on reset set state=LOAD_A, cnt=0, gemm_start=0, busy=0, load_err=0, a_rd_data=0, b_rd_data=0; matrix storage not cleared; reset mid-load or mid-RUN abandons the operation.

Configuration
REQ-030 SHALL, with GEMM_LOADER_LAST_CHECK_EN defined, set load_err when s_last=1 on any handshake other than the final B element or s_last=0 on the final B element; load still completes by count.
REQ-031 SHALL, without GEMM_LOADER_LAST_CHECK_EN, ignore s_last and tie load_err to 0.
REQ-032 SHALL hold load_err sticky until reset.

Structure
REQ-033 SHALL take default widths, ELEMS derivation and the state enum from shared package gemm_pkg.
REQ-034 SHALL instantiate sub-module gemm_operand_ram (one write port, one registered read port, ELEMS x DATA_WIDTH) twice, for A and B.

Verification
REQ-035 SHALL cover: continuous 32-beat stream values 1..32 -> A[0]=1, A[15]=16, B[0]=17, B[15]=32; gemm_start one cycle after beat 32.
REQ-036 SHALL cover: s_valid toggling 50% -> same stored contents as REQ-035, no beat lost or duplicated.
REQ-037 SHALL cover: s_valid held high in RUN -> s_ready=0, no writes; gemm_done pulse -> LOAD_A next cycle, s_ready=1.
REQ-038 SHALL cover: read a_rd_addr=5 while writing A[5]=0x00AA over 0x0006 -> old 0x0006 returned, then 0x00AA; a_rd_addr=16 -> 0.
REQ-039 SHALL cover: reset asserted after beat 10 -> s_ready=1, next beats land at A[0] onward, gemm_start only after 32 further beats.
REQ-040 SHALL cover, with GEMM_LOADER_LAST_CHECK_EN: s_last on beat 20 -> load_err=1 and stays 1 through gemm_done; correct s_last on beat 32 after reset -> load_err=0.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM operand loader: default widths, element-count
// helpers and the loader state encoding.
package gemm_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_ADDR_WIDTH  = 16;
  localparam int DEF_MATRIX_SIZE = 4;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    START  = 2'd2,
    RUN    = 2'd3
  } loader_state_e;

  function automatic int elems_of(input int n);
    return n * n;
  endfunction

  function automatic int idx_width(input int elems);
    return (elems > 1) ? $clog2(elems) : 1;
  endfunction

endpackage

// File: rtl/gemm_operand_ram.sv
// Single-write, single-registered-read operand store (ELEMS x DATA_WIDTH).
// Out-of-range reads return zero; a read colliding with a write returns old data.
module gemm_operand_ram
  import gemm_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ELEMS      = elems_of(DEF_MATRIX_SIZE),
  parameter int IDX_W      = idx_width(ELEMS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam logic [ADDR_WIDTH-1:0] ELEMS_A = ADDR_WIDTH'(ELEMS);

  logic [DATA_WIDTH-1:0] mem_q [ELEMS];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (raddr < ELEMS_A) begin
      rdata_q <= mem_q[raddr[IDX_W-1:0]];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/gemm_operand_loader.sv
// Streams an A then a B matrix (row-major) into two operand RAMs, then starts the GEMM.
// Optional s_last framing check enabled by defining GEMM_LOADER_LAST_CHECK_EN.
module gemm_operand_loader
  import gemm_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int MATRIX_SIZE = DEF_MATRIX_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  gemm_start,
  input  logic                  gemm_done,
  input  logic [ADDR_WIDTH-1:0] a_rd_addr,
  output logic [DATA_WIDTH-1:0] a_rd_data,
  input  logic [ADDR_WIDTH-1:0] b_rd_addr,
  output logic [DATA_WIDTH-1:0] b_rd_data,
  output logic                  busy,
  output logic                  load_err
);

  localparam int ELEMS = elems_of(MATRIX_SIZE);
  localparam int IDX_W = idx_width(ELEMS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS - 1);

  loader_state_e    state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             s_ready_q, gemm_start_q, busy_q;
  logic             hs, a_we, b_we;

  assign hs   = s_valid & s_ready_q;
  assign a_we = hs & (state_q == LOAD_A);
  assign b_we = hs & (state_q == LOAD_B);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOAD_A: begin
        if (hs) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = LOAD_B;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LOAD_B: begin
        if (hs) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = START;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      START:   state_d = RUN;
      RUN:     if (gemm_done) state_d = LOAD_A;
      default: state_d = LOAD_A;
    endcase
  end

  // Outputs are registered from the next state so they stay pure Moore signals.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= LOAD_A;
      cnt_q        <= '0;
      s_ready_q    <= 1'b1;
      gemm_start_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      s_ready_q    <= (state_d == LOAD_A) || (state_d == LOAD_B);
      gemm_start_q <= (state_d == START);
      busy_q       <= (state_d == START) || (state_d == RUN);
    end
  end

  assign s_ready    = s_ready_q;
  assign gemm_start = gemm_start_q;
  assign busy       = busy_q;

`ifdef GEMM_LOADER_LAST_CHECK_EN
  logic final_beat;
  logic load_err_q, load_err_d;

  assign final_beat = (state_q == LOAD_B) && (cnt_q == LAST_IDX);
  assign load_err_d = load_err_q | (hs & (s_last ^ final_beat));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) load_err_q <= 1'b0;
    else       load_err_q <= load_err_d;
  end

  assign load_err = load_err_q;
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign load_err      = 1'b0;
`endif

  gemm_operand_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ELEMS      (ELEMS),
    .IDX_W      (IDX_W)
  ) u_ram_a (
    .clk   (clk),
    .reset (reset),
    .we    (a_we),
    .waddr (cnt_q),
    .wdata (s_data),
    .raddr (a_rd_addr),
    .rdata (a_rd_data)
  );

  gemm_operand_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ELEMS      (ELEMS),
    .IDX_W      (IDX_W)
  ) u_ram_b (
    .clk   (clk),
    .reset (reset),
    .we    (b_we),
    .waddr (cnt_q),
    .wdata (s_data),
    .raddr (b_rd_addr),
    .rdata (b_rd_data)
  );

endmodule

// File: tb/tb_gemm_operand_loader.sv
// Directed/randomised bench for gemm_operand_loader against a beat-indexed matrix model.
// Expectations for load_err follow GEMM_LOADER_LAST_CHECK_EN.
module tb_gemm_operand_loader;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int N  = 4;
  localparam int EL = N * N;
  localparam int LAST_BEAT = 2 * EL - 1;
`ifdef GEMM_LOADER_LAST_CHECK_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, s_valid, s_ready, s_last, gemm_start, gemm_done, busy, load_err;
  logic [DW-1:0] s_data, a_rd_data, b_rd_data;
  logic [AW-1:0] a_rd_addr, b_rd_addr;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] a_m [EL];
  logic [DW-1:0] b_m [EL];
  bit            err_m;

  always #5 clk = ~clk;

  gemm_operand_loader #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .MATRIX_SIZE (N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .gemm_start (gemm_start),
    .gemm_done  (gemm_done),
    .a_rd_addr  (a_rd_addr),
    .a_rd_data  (a_rd_data),
    .b_rd_addr  (b_rd_addr),
    .b_rd_data  (b_rd_data),
    .busy       (busy),
    .load_err   (load_err)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic last, input bit gap);
    int n;
    if (gap) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    while (s_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("s_ready_in_load", s_ready, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Beat b of a frame: 0..EL-1 land in A, EL..2*EL-1 land in B.
  task automatic send_model(input int b, input logic [DW-1:0] d, input bit last, input bit gap);
    beat(d, last, gap);
    if (b < EL) a_m[b] = d;
    else        b_m[b-EL] = d;
    if (LAST_EN && (last != (b == LAST_BEAT))) err_m = 1'b1;
    chk("gemm_start_after_beat", gemm_start, (b == LAST_BEAT));
    chk("load_err_after_beat", load_err, err_m);
  endtask

  task automatic load_range(input int first, input int last_b, input int data_mode,
                            input int gap_mode, input int bad_beat);
    for (int b = first; b <= last_b; b++) begin
      logic [DW-1:0] d;
      bit gap;
      d   = (data_mode == 0) ? DW'(b + 1) : DW'($urandom);
      gap = (gap_mode == 0) ? 1'b0 : (gap_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      send_model(b, d, (b == LAST_BEAT) != (b == bad_beat), gap);
    end
  endtask

  task automatic finish_run(input bit hold_valid);
    @(posedge clk); #1;
    chk("gemm_start_one_cycle", gemm_start, 0);
    chk("busy_in_run", busy, 1);
    chk("s_ready_in_run", s_ready, 0);
    if (hold_valid) begin
      s_valid = 1'b1;
      s_data  = 16'hDEAD;
      s_last  = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        chk("s_ready_held_run", s_ready, 0);
        chk("busy_held_run", busy, 1);
      end
    end
    gemm_done = 1'b1;
    @(posedge clk); #1;
    gemm_done = 1'b0;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    chk("s_ready_after_done", s_ready, 1);
    chk("busy_after_done", busy, 0);
    chk("load_err_after_done", load_err, err_m);
  endtask

  task automatic read_all();
    for (int i = 0; i <= EL + 1; i++) begin
      int j;
      j = EL + 1 - i;
      a_rd_addr = AW'(i);
      b_rd_addr = AW'(j);
      @(posedge clk); #1;
      chk($sformatf("a_rd[%0d]", i), a_rd_data, (i < EL) ? a_m[i] : '0);
      chk($sformatf("b_rd[%0d]", j), b_rd_data, (j < EL) ? b_m[j] : '0);
    end
  endtask

  task automatic rd(input int aa, input int bb);
    a_rd_addr = AW'(aa);
    b_rd_addr = AW'(bb);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("reset_s_ready", s_ready, 1);
    chk("reset_gemm_start", gemm_start, 0);
    chk("reset_busy", busy, 0);
    chk("reset_load_err", load_err, 0);
    chk("reset_a_rd_data", a_rd_data, 0);
    chk("reset_b_rd_data", b_rd_data, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    err_m = 1'b0;
    chk("post_reset_s_ready", s_ready, 1);
  endtask

  initial begin
    logic [DW-1:0] old_a5;
    reset     = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    s_last    = 1'b0;
    gemm_done = 1'b0;
    a_rd_addr = '0;
    b_rd_addr = '0;
    err_m     = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Continuous stream 1..32, then s_valid held high while running.
    load_range(0, LAST_BEAT, 0, 0, -1);
    finish_run(1'b1);
    rd(0, 0);
    chk("A0_is_1", a_rd_data, 16'd1);
    chk("B0_is_17", b_rd_data, 16'd17);
    rd(15, 15);
    chk("A15_is_16", a_rd_data, 16'd16);
    chk("B15_is_32", b_rd_data, 16'd32);
    read_all();

    // gemm_done outside RUN has no effect.
    gemm_done = 1'b1;
    @(posedge clk); #1;
    gemm_done = 1'b0;
    @(posedge clk); #1;
    chk("done_ignored_s_ready", s_ready, 1);
    chk("done_ignored_busy", busy, 0);

    // Random data with random stalls.
    load_range(0, LAST_BEAT, 1, 2, -1);
    finish_run(1'b0);
    read_all();

    // Values 1..32 with s_valid toggling every other cycle.
    load_range(0, LAST_BEAT, 0, 1, -1);
    finish_run(1'b0);
    read_all();

    // Read-during-write on A[5].
    load_range(0, 4, 1, 0, -1);
    old_a5    = a_m[5];
    a_rd_addr = AW'(5);
    send_model(5, 16'h00AA, 1'b0, 1'b0);
    chk("rdw_returns_old", a_rd_data, old_a5);
    @(posedge clk); #1;
    chk("rdw_then_new", a_rd_data, 16'h00AA);
    a_rd_addr = AW'(EL);
    @(posedge clk); #1;
    chk("a_rd_out_of_range", a_rd_data, 0);
    load_range(6, LAST_BEAT, 1, 2, -1);
    finish_run(1'b0);
    read_all();

    // Reset after beat 10 abandons the load; a fresh 32-beat frame follows.
    load_range(0, 9, 1, 0, -1);
    do_reset();
    load_range(0, LAST_BEAT, 1, 2, -1);
    finish_run(1'b0);
    read_all();

    // Misplaced s_last on beat 20; error is sticky through gemm_done.
    load_range(0, LAST_BEAT, 1, 0, 19);
    finish_run(1'b1);
    chk("load_err_sticky", load_err, LAST_EN);
    do_reset();
    load_range(0, LAST_BEAT, 1, 0, -1);
    finish_run(1'b0);
    chk("load_err_clean_frame", load_err, 0);
    read_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
